// File: rtl/lobo_dot_accum_if.sv
// Stream/result handshake bundle for the lobo_dot_accum MAC accumulator.
// The master side drives products and control; the slave side is the accumulator.
interface lobo_dot_accum_if #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      p;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             sat;
    logic             busy;

    modport master (
        output start, len, p, in_valid, out_ready,
        input  in_ready, acc_out, out_valid, sat, busy
    );

    modport slave (
        input  start, len, p, in_valid, out_ready,
        output in_ready, acc_out, out_valid, sat, busy
    );
endinterface

// File: rtl/lobo_dot_accum.sv
// Streaming dot-product accumulator: sums len signed 32-bit products into a
// saturating ACC_W-bit accumulator and presents the result on a valid/ready port.
module lobo_dot_accum #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    lobo_dot_accum_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [LEN_W-1:0]        cnt;
    logic                    sat_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;

    logic signed [ACC_W:0]   sum_ext;
    logic signed [ACC_W-1:0] sum_sat;
    logic                    sum_ovf;

    // One guard bit above the accumulator: overflow shows as the top two bits differing.
    always_comb begin
        sum_ext = {acc[ACC_W-1], acc} + {{(ACC_W+1-32){bus.p[31]}}, bus.p};
        sum_ovf = sum_ext[ACC_W] != sum_ext[ACC_W-1];
        if (!sum_ovf)
            sum_sat = sum_ext[ACC_W-1:0];
        else if (sum_ext[ACC_W])
            sum_sat = ACC_MIN;
        else
            sum_sat = ACC_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            sat_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        sat_r  <= 1'b0;
                        busy_r <= 1'b1;
                        if (bus.len != '0) begin
                            cnt        <= bus.len;
                            state      <= RUN;
                            in_ready_r <= 1'b1;
                        end else begin
                            state       <= HOLD;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.in_valid && in_ready_r) begin
                        acc <= sum_sat;
                        cnt <= cnt - LEN_W'(1);
                        if (sum_ovf)
                            sat_r <= 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            state       <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sat       = sat_r;
    assign bus.acc_out   = acc;
endmodule

// File: tb/tb_lobo_dot_accum.sv
// Directed self-checking bench for lobo_dot_accum at ACC_W=34 so the
// saturation vectors reach both clamps with a handful of 32-bit products.
module tb_lobo_dot_accum;
    localparam int ACC_W = 34;
    localparam int LEN_W = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    lobo_dot_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    lobo_dot_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint acc_val();
        return longint'($signed(bus.acc_out));
    endfunction

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        step();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] v);
        bus.in_valid = 1'b1;
        bus.p        = v;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_ov_drop"}, longint'(bus.out_valid), 0);
        check({tag, "_idle"}, longint'(bus.busy), 0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.p         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", longint'(bus.in_ready), 0);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_sat", longint'(bus.sat), 0);
        check("rst_acc", acc_val(), 0);
        rst = 1'b0;
        step();

        // Basic sum: 10 - 3 + 100 - 7 = 100
        do_start(8'd4);
        check("basic_in_ready", longint'(bus.in_ready), 1);
        check("basic_busy", longint'(bus.busy), 1);
        feed(32'd10);
        feed(-32'sd3);
        feed(32'd100);
        check("basic_not_early", longint'(bus.out_valid), 0);
        feed(-32'sd7);
        check("basic_ov", longint'(bus.out_valid), 1);
        check("basic_in_ready_low", longint'(bus.in_ready), 0);
        check("basic_acc", acc_val(), 100);
        check("basic_sat", longint'(bus.sat), 0);
        handshake("basic");

        // Bubbles: 1,0,0,1,0,1 with p=5 -> 15, then 5-cycle output stall
        do_start(8'd3);
        begin
            logic [5:0] pat;
            pat = 6'b101001;
            for (int i = 0; i < 6; i++) begin
                bus.in_valid = pat[i];
                bus.p        = 32'd5;
                step();
            end
            bus.in_valid = 1'b0;
        end
        check("bubble_ov", longint'(bus.out_valid), 1);
        check("bubble_acc", acc_val(), 15);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_ov", longint'(bus.out_valid), 1);
            check("stall_acc", acc_val(), 15);
        end
        handshake("stall");

        // Zero length
        do_start(8'd0);
        check("zero_ov", longint'(bus.out_valid), 1);
        check("zero_in_ready", longint'(bus.in_ready), 0);
        check("zero_acc", acc_val(), 0);
        handshake("zero");

        // Positive saturation: 5 x 0x7FFFFFFF clamps at 2^33-1
        do_start(8'd5);
        for (int i = 0; i < 5; i++) feed(32'h7FFF_FFFF);
        check("psat_ov", longint'(bus.out_valid), 1);
        check("psat_acc", acc_val(), 64'sd8589934591);
        check("psat_sat", longint'(bus.sat), 1);
        handshake("psat");
        check("psat_sticky", longint'(bus.sat), 1);

        // Fresh run clears sat: -1 + -1 = -2
        do_start(8'd2);
        check("clr_sat", longint'(bus.sat), 0);
        feed(32'hFFFF_FFFF);
        feed(32'hFFFF_FFFF);
        check("neg2_ov", longint'(bus.out_valid), 1);
        check("neg2_acc", acc_val(), -2);
        check("neg2_sat", longint'(bus.sat), 0);
        handshake("neg2");

        // Negative saturation: 5 x 0x80000000 clamps at -2^33
        do_start(8'd5);
        for (int i = 0; i < 5; i++) feed(32'h8000_0000);
        check("nsat_acc", acc_val(), -64'sd8589934592);
        check("nsat_sat", longint'(bus.sat), 1);
        handshake("nsat");

        // Reset mid-run after 2 of 4 beats
        do_start(8'd4);
        feed(32'd7);
        feed(32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_in_ready", longint'(bus.in_ready), 0);
        check("mrst_out_valid", longint'(bus.out_valid), 0);
        check("mrst_busy", longint'(bus.busy), 0);
        check("mrst_acc", acc_val(), 0);
        check("mrst_sat", longint'(bus.sat), 0);

        // Start during RUN is ignored: count and acc carry on
        do_start(8'd3);
        feed(32'd20);
        do_start(8'd1);
        check("ign_in_ready", longint'(bus.in_ready), 1);
        feed(32'd30);
        check("ign_not_early", longint'(bus.out_valid), 0);
        feed(32'd40);
        check("ign_ov", longint'(bus.out_valid), 1);
        check("ign_acc", acc_val(), 90);
        do_start(8'd2);
        check("ign_hold_ov", longint'(bus.out_valid), 1);
        check("ign_hold_acc", acc_val(), 90);
        handshake("ign");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
